// File: rtl/rf_pkg.sv
// Shared types and constants for the register-file write-back path.
package rf_pkg;
    localparam int unsigned PW   = 3;
    localparam int unsigned DW   = 8;
    localparam int unsigned NREG = 2 ** PW;

    typedef logic [PW-1:0] reg_addr_t;
    typedef logic [DW-1:0] data_t;

    typedef enum logic {
        GNT_ALU = 1'b0,
        GNT_MEM = 1'b1
    } gnt_t;
endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Write-back request bundle from the ALU and load producers to the arbiter.
interface rf_wb_arbiter_if
    import rf_pkg::*;
#(
    parameter int unsigned pw = PW,
    parameter int unsigned dw = DW
);
    logic          a_valid;
    logic          a_ready;
    logic [pw-1:0] a_addr;
    logic [dw-1:0] a_data;
    logic          m_valid;
    logic          m_ready;
    logic [pw-1:0] m_addr;
    logic [dw-1:0] m_data;

    modport master (
        output a_valid, a_addr, a_data, m_valid, m_addr, m_data,
        input  a_ready, m_ready
    );

    modport slave (
        input  a_valid, a_addr, a_data, m_valid, m_addr, m_data,
        output a_ready, m_ready
    );
endinterface

// File: rtl/rf_scoreboard.sv
// Pending-write bitmap: set on issue, cleared on commit, with WAW stall and RAW hazard lookup.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int unsigned pw = PW
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               iss_valid,
    input  logic [pw-1:0]      iss_addr,
    input  logic               wr_en,
    input  logic [pw-1:0]      wr_addr,
    input  logic [pw-1:0]      chk_addrA,
    input  logic [pw-1:0]      chk_addrB,
    output logic [2**pw-1:0]   busy,
    output logic               iss_stall,
    output logic               hazard
);
    logic [2**pw-1:0] busy_q;
    logic [2**pw-1:0] busy_d;

    always_comb begin
        iss_stall = rst_n && iss_valid && busy_q[iss_addr] &&
                    !(wr_en && (wr_addr == iss_addr));
        hazard    = rst_n && (busy_q[chk_addrA] || busy_q[chk_addrB]);
        busy_d    = busy_q;
        // Clear first so a same-cycle issue to the committing register keeps it busy.
        if (wr_en)
            busy_d[wr_addr] = 1'b0;
        if (iss_valid && !iss_stall)
            busy_d[iss_addr] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            busy_q <= '0;
        else
            busy_q <= busy_d;
    end

    assign busy = busy_q;
endmodule

// File: rtl/rf_wb_arbiter.sv
// Round-robin write-back arbiter driving the register file write port through a one-cycle output stage.
module rf_wb_arbiter
    import rf_pkg::*;
#(
    parameter int unsigned pw = PW,
    parameter int unsigned dw = DW
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               hold,
    rf_wb_arbiter_if.slave     wb,
    input  logic               iss_valid,
    input  logic [pw-1:0]      iss_addr,
    output logic               iss_stall,
    input  logic [pw-1:0]      chk_addrA,
    input  logic [pw-1:0]      chk_addrB,
    output logic               hazard,
    output logic               wr_en,
    output logic [pw-1:0]      wr_addr,
    output logic [dw-1:0]      dat_in,
    output logic [2**pw-1:0]   busy,
    output logic [15:0]        wb_count
);
    gnt_t ptr;
    gnt_t ptr_next;
    logic a_gnt;
    logic m_gnt;

    // ptr names the requester that wins when both are valid.
    always_comb begin
        a_gnt    = 1'b0;
        m_gnt    = 1'b0;
        ptr_next = ptr;
        if (rst_n && !hold) begin
            if (wb.a_valid && (!wb.m_valid || ptr == GNT_ALU))
                a_gnt = 1'b1;
            else if (wb.m_valid)
                m_gnt = 1'b1;
        end
        if (a_gnt)
            ptr_next = GNT_MEM;
        else if (m_gnt)
            ptr_next = GNT_ALU;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ptr <= GNT_ALU;
        else
            ptr <= ptr_next;
    end

    assign wb.a_ready = a_gnt;
    assign wb.m_ready = m_gnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            dat_in   <= '0;
            wb_count <= '0;
        end else begin
            wr_en <= a_gnt || m_gnt;
            if (a_gnt) begin
                wr_addr <= wb.a_addr;
                dat_in  <= wb.a_data;
            end else if (m_gnt) begin
                wr_addr <= wb.m_addr;
                dat_in  <= wb.m_data;
            end
            if (wr_en)
                wb_count <= wb_count + 16'd1;
        end
    end

    rf_scoreboard #(.pw(pw)) u_scoreboard (
        .clk       (clk),
        .rst_n     (rst_n),
        .iss_valid (iss_valid),
        .iss_addr  (iss_addr),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .chk_addrA (chk_addrA),
        .chk_addrB (chk_addrB),
        .busy      (busy),
        .iss_stall (iss_stall),
        .hazard    (hazard)
    );
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed and randomized checks of rf_wb_arbiter against a cycle-level behavioural model.
module tb_rf_wb_arbiter;
    logic        clk;
    logic        rst_n;
    logic        hold;
    logic        iss_valid;
    logic [2:0]  iss_addr;
    logic        iss_stall;
    logic [2:0]  chk_addrA;
    logic [2:0]  chk_addrB;
    logic        hazard;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [7:0]  dat_in;
    logic [7:0]  busy;
    logic [15:0] wb_count;

    rf_wb_arbiter_if wb ();

    rf_wb_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .hold      (hold),
        .wb        (wb),
        .iss_valid (iss_valid),
        .iss_addr  (iss_addr),
        .iss_stall (iss_stall),
        .chk_addrA (chk_addrA),
        .chk_addrB (chk_addrB),
        .hazard    (hazard),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .dat_in    (dat_in),
        .busy      (busy),
        .wb_count  (wb_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model state: who won last, which registers await a write, what the port shows.
    int          last_gnt;
    bit          pend [8];
    bit          m_wr_en;
    logic [2:0]  m_wr_addr;
    logic [7:0]  m_dat;
    logic [15:0] m_cnt;
    int          gseq [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        last_gnt  = 1;
        for (int i = 0; i < 8; i++) pend[i] = 1'b0;
        m_wr_en   = 1'b0;
        m_wr_addr = '0;
        m_dat     = '0;
        m_cnt     = '0;
    endtask

    function automatic logic [7:0] pend_vec();
        logic [7:0] v;
        for (int i = 0; i < 8; i++) v[i] = pend[i];
        return v;
    endfunction

    task automatic expect_now(output bit ea, output bit em, output bit es);
        ea = !hold && wb.a_valid && (!wb.m_valid || last_gnt == 1);
        em = !hold && wb.m_valid && (!wb.a_valid || last_gnt == 0);
        es = iss_valid && pend[iss_addr] && !(m_wr_en && m_wr_addr == iss_addr);
    endtask

    task automatic check_all();
        bit ea, em, es;
        expect_now(ea, em, es);
        check("a_ready",   wb.a_ready, ea);
        check("m_ready",   wb.m_ready, em);
        check("iss_stall", iss_stall, es);
        check("hazard",    hazard, pend[chk_addrA] || pend[chk_addrB]);
        check("wr_en",     wr_en, m_wr_en);
        check("wr_addr",   wr_addr, m_wr_addr);
        check("dat_in",    dat_in, m_dat);
        check("busy",      busy, pend_vec());
        check("wb_count",  wb_count, m_cnt);
        if (wb.a_ready) gseq.push_back(0);
        if (wb.m_ready) gseq.push_back(1);
    endtask

    task automatic model_step();
        bit ea, em, es;
        expect_now(ea, em, es);
        if (m_wr_en) begin
            m_cnt = m_cnt + 16'd1;
            pend[m_wr_addr] = 1'b0;
        end
        if (iss_valid && !es) pend[iss_addr] = 1'b1;
        m_wr_en = ea || em;
        if (ea) begin
            m_wr_addr = wb.a_addr; m_dat = wb.a_data; last_gnt = 0;
        end else if (em) begin
            m_wr_addr = wb.m_addr; m_dat = wb.m_data; last_gnt = 1;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check_all();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle();
        wb.a_valid = 1'b0; wb.m_valid = 1'b0; iss_valid = 1'b0; hold = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        wb.a_valid = 1'b1; wb.m_valid = 1'b1; iss_valid = 1'b1;
        rst_n = 1'b0;
        #1;
        check("rst_wr_en",    wr_en, 1'b0);
        check("rst_wr_addr",  wr_addr, 3'd0);
        check("rst_dat_in",   dat_in, 8'd0);
        check("rst_busy",     busy, 8'd0);
        check("rst_wb_count", wb_count, 16'd0);
        check("rst_readies",  {wb.a_ready, wb.m_ready, iss_stall, hazard}, 4'b0000);
        model_reset();
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; hold = 1'b0; iss_valid = 1'b0; iss_addr = '0;
        chk_addrA = '0; chk_addrB = '0;
        wb.a_valid = 1'b0; wb.a_addr = '0; wb.a_data = '0;
        wb.m_valid = 1'b0; wb.m_addr = '0; wb.m_data = '0;
        #2;
        do_reset();

        // Single ALU write.
        wb.a_valid = 1'b1; wb.a_addr = 3'd3; wb.a_data = 8'd42;
        tick();
        idle();
        check("t1_wr", {wr_en, wr_addr, dat_in}, {1'b1, 3'd3, 8'd42});
        tick();
        check("t1_done", {wr_en, wb_count}, {1'b0, 16'd1});

        // Both requesters for four cycles from a fresh pointer.
        do_reset();
        gseq.delete();
        wb.a_valid = 1'b1; wb.a_addr = 3'd1; wb.a_data = 8'd10;
        wb.m_valid = 1'b1; wb.m_addr = 3'd2; wb.m_data = 8'd20;
        repeat (4) tick();
        idle();
        check("rr_len", gseq.size(), 4);
        if (gseq.size() == 4)
            check("rr_order", {gseq[0][0], gseq[1][0], gseq[2][0], gseq[3][0]}, 4'b0101);
        tick();
        check("rr_count", wb_count, 16'd4);

        // RAW hazard lifetime on register 5.
        iss_valid = 1'b1; iss_addr = 3'd5;
        tick();
        idle();
        chk_addrA = 3'd5; chk_addrB = 3'd0;
        check("sb_set", busy[5], 1'b1);
        tick();
        wb.m_valid = 1'b1; wb.m_addr = 3'd5; wb.m_data = 8'd7;
        tick();
        idle();
        tick();
        check("sb_clear", busy[5], 1'b0);
        tick();

        // WAW stall, then issue coinciding with the commit.
        iss_valid = 1'b1; iss_addr = 3'd5;
        tick();
        tick();
        check("waw_keep", busy[5], 1'b1);
        iss_valid = 1'b0;
        wb.m_valid = 1'b1; wb.m_addr = 3'd5; wb.m_data = 8'd9;
        tick();
        wb.m_valid = 1'b0;
        iss_valid = 1'b1; iss_addr = 3'd5;
        tick();
        idle();
        check("set_wins", busy[5], 1'b1);

        // Hold blocks both, then ALU wins.
        hold = 1'b1;
        wb.a_valid = 1'b1; wb.a_addr = 3'd4; wb.a_data = 8'h44;
        wb.m_valid = 1'b1; wb.m_addr = 3'd6; wb.m_data = 8'h66;
        gseq.delete();
        repeat (3) tick();
        check("hold_none", gseq.size(), 0);
        hold = 1'b0;
        tick();
        idle();
        check("hold_first", (gseq.size() == 1) ? gseq[0] : 2, 0);
        tick();

        // Reset while a write sits in the output stage.
        wb.a_valid = 1'b1; wb.a_addr = 3'd6; wb.a_data = 8'h55;
        tick();
        idle();
        check("mid_pre", wr_en, 1'b1);
        do_reset();
        tick();

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            hold       = ($urandom_range(0, 9) == 0);
            wb.a_valid = $urandom_range(0, 1);
            wb.a_addr  = 3'($urandom);
            wb.a_data  = 8'($urandom);
            wb.m_valid = $urandom_range(0, 1);
            wb.m_addr  = 3'($urandom);
            wb.m_data  = 8'($urandom);
            iss_valid  = ($urandom_range(0, 2) == 0);
            iss_addr   = 3'($urandom);
            chk_addrA  = 3'($urandom);
            chk_addrB  = 3'($urandom);
            tick();
        end
        idle();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
